// File: rtl/uart_host_link_pkg.sv
// Shared definitions for the host side of the instruction / register-dump UART link.
// The byte-order helpers are the same rule the processor-side register file uses.
package uart_host_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_START = 3'd1,
        ST_TX_WAIT  = 3'd2,
        ST_RX_DUMP  = 3'd3,
        ST_ABORT    = 3'd4
    } state_t;

    localparam int DUMP_BYTES = 128;
    localparam int INST_BYTES = 4;

    // Dump byte n carries bits 8*(n%4)+:8 of register n/4 (least-significant byte first).
    function automatic logic [4:0] dump_word_index(input logic [6:0] n);
        return n[6:2];
    endfunction

    function automatic logic [1:0] dump_byte_lane(input logic [6:0] n);
        return n[1:0];
    endfunction

endpackage

// File: rtl/uart_host_link_if.sv
// Local-logic side of the link: instruction handshake in, shadow register writes out.
interface uart_host_link_if;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        dump_done;
    logic        timeout_err;
    logic        busy;

    modport master (
        output inst_valid, inst_data,
        input  inst_ready, reg_wr_en, reg_wr_addr, reg_wr_data, dump_done, timeout_err, busy
    );

    modport slave (
        input  inst_valid, inst_data,
        output inst_ready, reg_wr_en, reg_wr_addr, reg_wr_data, dump_done, timeout_err, busy
    );
endinterface

// File: rtl/uart_host_link_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser and mid-bit sampling.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv
);
    logic [1:0]  r_sync;
    logic        r_active;
    logic [3:0]  r_bit_idx;
    logic [15:0] r_clk_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_rcv;
    logic [15:0] w_limit;

    // First wait is half a bit to land in the middle of the start bit.
    assign w_limit = (r_bit_idx == 4'd0) ? 16'(CLKS_PER_BIT / 2 - 1) : 16'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= 2'b11;
            r_active  <= 1'b0;
            r_bit_idx <= '0;
            r_clk_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_rcv     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_rcv  <= 1'b0;
            if (!r_active) begin
                if (!r_sync[1]) begin
                    r_active  <= 1'b1;
                    r_bit_idx <= '0;
                    r_clk_cnt <= '0;
                end
            end else if (r_clk_cnt == w_limit) begin
                r_clk_cnt <= '0;
                if (r_bit_idx == 4'd0) begin
                    if (r_sync[1]) r_active <= 1'b0;
                    else           r_bit_idx <= 4'd1;
                end else if (r_bit_idx == 4'd9) begin
                    r_active <= 1'b0;
                    if (r_sync[1]) begin
                        r_data <= r_shift;
                        r_rcv  <= 1'b1;
                    end
                end else begin
                    r_shift   <= {r_sync[1], r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 4'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + 16'd1;
            end
        end
    end

    assign data = r_data;
    assign rcv  = r_rcv;
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start accepted while ready, LSB first, line idles high.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       ready
);
    logic        r_busy;
    logic        r_tx;
    logic [8:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_clk_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
        end else if (!r_busy) begin
            if (start) begin
                r_busy    <= 1'b1;
                r_tx      <= 1'b0;
                r_shift   <= {1'b1, data};
                r_bit_cnt <= '0;
                r_clk_cnt <= '0;
            end
        end else if (r_clk_cnt == 16'(CLKS_PER_BIT - 1)) begin
            r_clk_cnt <= '0;
            // Period 9 is the stop bit; the line is already high when it ends.
            if (r_bit_cnt == 4'd9) begin
                r_busy <= 1'b0;
            end else begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
        end
    end

    assign tx    = r_tx;
    assign ready = ~r_busy;
endmodule

// File: rtl/uart_host_link.sv
// Host endpoint: sends a 32-bit instruction as four UART bytes, then rebuilds the
// 128-byte register dump into 32 word writes, aborting if the processor goes quiet.
module uart_host_link
    import uart_host_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 104,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
    input  logic             clk12,
    input  logic             rstn,
    input  logic             rx,
    output logic             tx,
    uart_host_link_if.slave  host
);
    logic        w_tx_start;
    logic        w_tx_ready;
    logic        w_rcv;
    logic [7:0]  w_rx_data;

    state_t      r_state;
    logic [31:0] r_shift;
    logic [1:0]  r_byte_cnt;
    logic [6:0]  r_rx_cnt;
    logic [23:0] r_tmo_cnt;
    logic [23:0] r_word_buf;
    logic        r_inst_ready;
    logic        r_busy;
    logic        r_reg_wr_en;
    logic [4:0]  r_reg_wr_addr;
    logic [31:0] r_reg_wr_data;
    logic        r_dump_done;
    logic        r_timeout_err;

    assign w_tx_start = (r_state == ST_TX_START);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk12),
        .rstn  (rstn),
        .data  (r_shift[7:0]),
        .start (w_tx_start),
        .tx    (tx),
        .ready (w_tx_ready)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk  (clk12),
        .rstn (rstn),
        .rx   (rx),
        .data (w_rx_data),
        .rcv  (w_rcv)
    );

    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_rx_cnt      <= '0;
            r_tmo_cnt     <= '0;
            r_word_buf    <= '0;
            r_inst_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_addr <= '0;
            r_reg_wr_data <= '0;
            r_dump_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_reg_wr_en   <= 1'b0;
            r_dump_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rx_cnt <= '0;
                    // inst_ready re-arms one cycle after returning here.
                    if (host.inst_valid && r_inst_ready) begin
                        r_shift      <= host.inst_data;
                        r_byte_cnt   <= '0;
                        r_inst_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_TX_START;
                    end else begin
                        r_inst_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                ST_TX_START: begin
                    if (!w_tx_ready) r_state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (w_tx_ready) begin
                        if (r_byte_cnt == 2'(INST_BYTES - 1)) begin
                            r_rx_cnt  <= '0;
                            r_tmo_cnt <= '0;
                            r_state   <= ST_RX_DUMP;
                        end else begin
                            r_shift    <= {8'h00, r_shift[31:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_state    <= ST_TX_START;
                        end
                    end
                end
                ST_RX_DUMP: begin
                    if (w_rcv) begin
                        r_rx_cnt  <= r_rx_cnt + 7'd1;
                        r_tmo_cnt <= '0;
                        case (dump_byte_lane(r_rx_cnt))
                            2'd0:    r_word_buf[7:0]   <= w_rx_data;
                            2'd1:    r_word_buf[15:8]  <= w_rx_data;
                            2'd2:    r_word_buf[23:16] <= w_rx_data;
                            default: begin
                                r_reg_wr_en   <= 1'b1;
                                r_reg_wr_addr <= dump_word_index(r_rx_cnt);
                                r_reg_wr_data <= {w_rx_data, r_word_buf};
                            end
                        endcase
                        if (r_rx_cnt == 7'(DUMP_BYTES - 1)) begin
                            r_dump_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (r_tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        r_state <= ST_ABORT;
                    end else if (r_tmo_cnt != '1) begin
                        r_tmo_cnt <= r_tmo_cnt + 24'd1;
                    end
                end
                ST_ABORT: begin
                    r_timeout_err <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host.inst_ready  = r_inst_ready;
    assign host.busy        = r_busy;
    assign host.reg_wr_en   = r_reg_wr_en;
    assign host.reg_wr_addr = r_reg_wr_addr;
    assign host.reg_wr_data = r_reg_wr_data;
    assign host.dump_done   = r_dump_done;
    assign host.timeout_err = r_timeout_err;
endmodule

// File: doc/uart_host_link.md
# uart_host_link

Host-side endpoint of the instruction/register-dump UART link, the counterpart of the processor-side UART register file. Accepts a 32-bit instruction from local logic, serialises it over UART as four bytes, then collects the 128-byte register-file dump the processor returns. The dump is reassembled into 32 word writes for a local shadow register file or checker. Intended for FPGA-to-FPGA bring-up and for self-checking loopback benches.

## Interface

- BAUDRATE, `B115200 — divider define passed to the UART tx/rx cores.
- TIMEOUT_CYCLES, 24'd1_200_000 — clk12 cycles allowed between received dump bytes (about 100 ms) before the dump is aborted.
- clk12  in  1  system clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- rx  in  1  UART line from the processor side; carries the dump.
- tx  out  1  UART line to the processor side; carries the instruction. Idles high.
- inst_valid  in  1  instruction request.
- inst_data  in  32  instruction to send.
- inst_ready  out  1  high only in IDLE; a transfer starts when inst_valid && inst_ready.
- reg_wr_en  out  1  one-cycle pulse per completed dump word.
- reg_wr_addr  out  5  register index of the word, 0..31.
- reg_wr_data  out  32  assembled word.
- dump_done  out  1  one-cycle pulse after word 31 is written.
- timeout_err  out  1  one-cycle pulse when a dump is aborted.
- busy  out  1  high in every state except IDLE.

## Operation

- Byte order, both directions: least-significant byte first. The instruction goes out as inst_data[7:0], [15:8], [23:16], [31:24]. Dump byte n is bits 8*(n%4)+:8 of register n/4, starting at register 0.
- States: IDLE, TX_START, TX_WAIT, RX_DUMP, ABORT.
- IDLE: on handshake, latch inst_data into a 32-bit shift register, set byte_cnt=0, go to TX_START.
- TX_START: assert tx start with the low byte. When the tx core drops ready, go to TX_WAIT.
- TX_WAIT: when ready returns high:
  - if byte_cnt==3, go to RX_DUMP with rx_cnt=0 and the timeout counter cleared;
  - otherwise shift right by 8, increment byte_cnt, go to TX_START.
- RX_DUMP: on each rx byte strobe, write the byte into word_buf[8*rx_cnt[1:0]+:8], increment rx_cnt (7 bits), and clear the timeout counter.
  - When rx_cnt[1:0]==3 on that strobe: pulse reg_wr_en the next cycle, with reg_wr_addr=rx_cnt[6:2] and the completed word.
  - When rx_cnt==127 on that strobe: also pulse dump_done in the same cycle as the final reg_wr_en, then return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 in RX_DUMP, go to ABORT. ABORT pulses timeout_err for one cycle and returns to IDLE. Words already written stay written; no partial word is written.
- Rx bytes arriving in IDLE, TX_START or TX_WAIT are dropped. A new inst_valid while busy is ignored.
- Reset mid-operation: all state is discarded immediately and the block returns to IDLE. tx returns to idle high within one cycle, even mid-frame.

## Timing

- Reset values: tx=1, inst_ready=1, busy=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, dump_done=0, timeout_err=0. State is IDLE, counters are 0.
- The handshake cycle is the cycle with inst_valid && inst_ready. inst_ready and busy change in the following cycle.
- The tx start bit begins no later than two cycles after the handshake. Bytes are sent back-to-back with at most two idle cycles between stop bit and next start bit.
- reg_wr_en follows the rx strobe of a word's fourth byte by exactly one cycle. Write data and address are stable only during the pulse.
- inst_ready rises the cycle after dump_done or timeout_err.
- rx_cnt wraps 127→0 only on return to IDLE. The timeout counter is 24 bits and saturates; it never wraps.

## Structure

- Shared package holds:
  - state encoding constants;
  - the DUMP_BYTES=128 and INST_BYTES=4 constants;
  - the byte-order rule, shared with the processor-side block.
- Reuse the existing uart_tx core (clk, rstn, data, start, tx, ready).
- One sub-module: uart_rx, the byte receiver. Ports: clk, rstn, rx, data[7:0], rcv as a one-cycle strobe. It performs 2-flop input synchronisation and mid-bit sampling.
- Top FSM, shift register, counters and word assembly stay in uart_host_link.

## Test plan

- Send inst_data=32'h00500093; the bench UART model decodes bytes 0x93, 0x00, 0x50, 0x00 in order. busy stays high throughout.
- After the instruction, the model returns 128 bytes where register k = 32'hA5000000|k. Expect 32 reg_wr_en pulses with addr 0..31 and matching data, and dump_done coincident with the addr=31 write.
- The model stops after byte 70; with TIMEOUT_CYCLES=1000, expect writes for addr 0..16 only. timeout_err pulses 1000 cycles after the last strobe, then inst_ready=1.
- inst_valid held high across a full transaction: exactly one instruction is sent. A second transfer starts only after dump_done.
- Rx bytes injected while in IDLE are ignored: no reg_wr_en and no state change.
- rstn asserted mid-byte during the instruction: tx is high within one cycle and all outputs are at reset values. A subsequent normal transaction passes.
